// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg
// Shared types and default sizing for the L2 <-> main_memory line sequencer.
//   state_t  - sequencer FSM states
//   phase_t  - which half of a line operation is running (writeback or fill)
//   N, ADDR_W, BLOCK_WORDS, OFFSET_W - default word width, word-address width,
//   words per line and word-offset width inside a line
package l2_mem_pkg;

    localparam int N           = 32;
    localparam int ADDR_W      = 15;
    localparam int BLOCK_WORDS = 4;
    localparam int OFFSET_W    = $clog2(BLOCK_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        PH_WB   = 1'b0,
        PH_FILL = 1'b1
    } phase_t;

endpackage

// File: rtl/l2_mem_sequencer_if.sv
// l2_mem_sequencer_if
// Bundles the L2-controller request/response signals and the main_memory
// request/busy signals seen by the line sequencer.
//   modport slave  - the sequencer: takes line operations, drives memory requests
//   modport master - the L2 controller plus main_memory side
interface l2_mem_sequencer_if #(
    parameter int n          = l2_mem_pkg::N,
    parameter int block_size = l2_mem_pkg::BLOCK_WORDS,
    parameter int ADDR_W     = l2_mem_pkg::ADDR_W
) ();
    localparam int LINE_W = ADDR_W - $clog2(block_size);

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wb;
    logic                    req_fill;
    logic [LINE_W-1:0]       wb_line_addr;
    logic [LINE_W-1:0]       fill_line_addr;
    logic [block_size*n-1:0] wb_line;
    logic [block_size*n-1:0] fill_line;
    logic                    done;

    logic                    L2_read_request;
    logic                    L2_write_request;
    logic [ADDR_W-1:0]       L2_word_address;
    logic [n-1:0]            L2_wdata;
    logic [n-1:0]            L2_rdata;
    logic                    MM_busy;

    modport slave (
        input  req_valid, req_wb, req_fill, wb_line_addr, fill_line_addr, wb_line,
        input  L2_rdata, MM_busy,
        output req_ready, fill_line, done,
        output L2_read_request, L2_write_request, L2_word_address, L2_wdata
    );

    modport master (
        output req_valid, req_wb, req_fill, wb_line_addr, fill_line_addr, wb_line,
        output L2_rdata, MM_busy,
        input  req_ready, fill_line, done,
        input  L2_read_request, L2_write_request, L2_word_address, L2_wdata
    );

endinterface

// File: rtl/l2_line_buffer.sv
// l2_line_buffer
// Fill-line assembly buffer: block_size words of n bits, one indexed word
// written per cycle, whole line visible on a flat output.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low clear of every word
//   i_we    - write enable for word i_idx
//   i_idx   - word index inside the line
//   i_wdata - word to store
//   o_line  - flat line, word i at [i*n +: n]
module l2_line_buffer
    import l2_mem_pkg::*;
#(
    parameter int n          = N,
    parameter int block_size = BLOCK_WORDS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_we,
    input  logic [$clog2(block_size)-1:0] i_idx,
    input  logic [n-1:0]                  i_wdata,
    output logic [block_size*n-1:0]       o_line
);

    logic [n-1:0] r_mem [block_size];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < block_size; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    for (genvar g = 0; g < block_size; g++) begin : g_out
        assign o_line[g*n +: n] = r_mem[g];
    end

endmodule

// File: rtl/l2_mem_sequencer.sv
// l2_mem_sequencer
// Breaks one L2 line operation (writeback, fill, or writeback-then-fill) into
// single-word main_memory accesses and returns the filled line with a done pulse.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset; drops any in-flight operation
//   l2_bus - L2 request/response and main_memory request/busy (slave modport)
//
// state | meaning
// IDLE  | ready; accepts req_valid
// ISSUE | request for word r_idx driven, waiting for MM_busy to rise
// WAIT  | access in progress, word completes on first MM_busy low
// GAP   | both requests low for one cycle before the next word or DONE
// DONE  | done pulse, then back to IDLE
module l2_mem_sequencer #(
    parameter int n          = l2_mem_pkg::N,
    parameter int block_size = l2_mem_pkg::BLOCK_WORDS,
    parameter int ADDR_W     = l2_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    l2_mem_sequencer_if.slave l2_bus
);
    import l2_mem_pkg::*;

    localparam int                OFF_W    = $clog2(block_size);
    localparam int                LINE_W   = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0]  LAST_IDX = OFF_W'(block_size - 1);

    state_t                  r_state, w_state_nx;
    phase_t                  r_phase, w_phase_nx;
    logic [OFF_W-1:0]        r_idx, w_idx_nx;
    logic                    w_accept;
    logic                    w_buf_we;

    logic [LINE_W-1:0]       r_wb_addr, w_wb_addr_nx;
    logic [LINE_W-1:0]       r_fill_addr, w_fill_addr_nx;
    logic [block_size*n-1:0] r_wb_line, w_wb_line_nx;
    logic                    r_do_fill, w_do_fill_nx;

    logic                    r_req_ready, r_done, r_rd_req, r_wr_req;
    logic [ADDR_W-1:0]       r_addr, w_addr_nx;
    logic [n-1:0]            r_wdata, w_wdata_nx;
    logic                    w_req_active_nx;
    logic [LINE_W-1:0]       w_line_sel_nx;
    logic [block_size*n-1:0] w_fill_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_WB;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_idx_nx   = r_idx;
        w_accept   = 1'b0;
        w_buf_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (l2_bus.req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    w_idx_nx = '0;
                    if (l2_bus.req_wb) begin
                        w_state_nx = ST_ISSUE;
                        w_phase_nx = PH_WB;
                    end else if (l2_bus.req_fill) begin
                        w_state_nx = ST_ISSUE;
                        w_phase_nx = PH_FILL;
                    end else begin
                        w_state_nx = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (l2_bus.MM_busy) begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!l2_bus.MM_busy) begin
                    w_buf_we   = (r_phase == PH_FILL);
                    w_state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_idx != LAST_IDX) begin
                    w_idx_nx   = r_idx + OFF_W'(1);
                    w_state_nx = ST_ISSUE;
                end else if (r_phase == PH_WB && r_do_fill) begin
                    w_phase_nx = PH_FILL;
                    w_idx_nx   = '0;
                    w_state_nx = ST_ISSUE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Capture on acceptance; the next-cycle view is used so outputs for the
    // first word can be registered on the acceptance edge.
    always_comb begin
        w_wb_addr_nx   = w_accept ? l2_bus.wb_line_addr   : r_wb_addr;
        w_fill_addr_nx = w_accept ? l2_bus.fill_line_addr : r_fill_addr;
        w_wb_line_nx   = w_accept ? l2_bus.wb_line        : r_wb_line;
        w_do_fill_nx   = w_accept ? l2_bus.req_fill       : r_do_fill;

        w_req_active_nx = (w_state_nx == ST_ISSUE) || (w_state_nx == ST_WAIT);
        w_line_sel_nx   = (w_phase_nx == PH_WB) ? w_wb_addr_nx : w_fill_addr_nx;
        w_addr_nx       = w_req_active_nx ? {w_line_sel_nx, w_idx_nx} : r_addr;
        w_wdata_nx      = (w_req_active_nx && w_phase_nx == PH_WB)
                          ? w_wb_line_nx[w_idx_nx*n +: n] : r_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_addr   <= '0;
            r_fill_addr <= '0;
            r_wb_line   <= '0;
            r_do_fill   <= 1'b0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_rd_req    <= 1'b0;
            r_wr_req    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_wb_addr   <= w_wb_addr_nx;
            r_fill_addr <= w_fill_addr_nx;
            r_wb_line   <= w_wb_line_nx;
            r_do_fill   <= w_do_fill_nx;
            r_req_ready <= (w_state_nx == ST_IDLE);
            r_done      <= (w_state_nx == ST_DONE);
            r_rd_req    <= w_req_active_nx && (w_phase_nx == PH_FILL);
            r_wr_req    <= w_req_active_nx && (w_phase_nx == PH_WB);
            r_addr      <= w_addr_nx;
            r_wdata     <= w_wdata_nx;
        end
    end

    l2_line_buffer #(
        .n          (n),
        .block_size (block_size)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_buf_we),
        .i_idx   (r_idx),
        .i_wdata (l2_bus.L2_rdata),
        .o_line  (w_fill_line)
    );

    assign l2_bus.req_ready        = r_req_ready;
    assign l2_bus.done             = r_done;
    assign l2_bus.L2_read_request  = r_rd_req;
    assign l2_bus.L2_write_request = r_wr_req;
    assign l2_bus.L2_word_address  = r_addr;
    assign l2_bus.L2_wdata         = r_wdata;
    assign l2_bus.fill_line        = w_fill_line;

endmodule

// File: tb/tb_l2_mem_sequencer.sv
// tb_l2_mem_sequencer
// Drives line operations into l2_mem_sequencer against a main_memory model and
// checks memory traffic and returned lines against a line-level reference model.
module tb_l2_mem_sequencer;
    import l2_mem_pkg::*;

    localparam int LW = ADDR_W - OFFSET_W;
    localparam int LB = BLOCK_WORDS * N;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l2_mem_sequencer_if bus ();

    l2_mem_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .l2_bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  ram     [2**ADDR_W];
    logic [N-1:0]  ref_mem [2**ADDR_W];
    logic [LB-1:0] ref_fill = '0;
    acc_t          exp_acc  [$];
    logic [LB-1:0] exp_done [$];

    logic              mm_busy  = 1'b0;
    logic [N-1:0]      mm_rdata = '0;
    int                mm_phase = 0;
    int                mm_left  = 0;
    int                mm_lat   = 2;
    logic              mm_wr;
    logic [ADDR_W-1:0] mm_addr;
    logic [N-1:0]      mm_data;
    acc_t              mm_e;
    int                acc_done = 0;
    int                done_cnt = 0;
    logic              prev_done = 1'b0;
    logic [LB-1:0]     ed;

    assign bus.MM_busy  = mm_busy;
    assign bus.L2_rdata = mm_rdata;

    function automatic void check(string nm, logic [LB-1:0] act, logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached", nm);
    endfunction

    function automatic logic [N-1:0] init_word(int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Reference model: a line operation is all writes of the dirty line, then
    // all reads of the fill line, from a flat word-addressed memory.
    task automatic model_op(input bit wb, input bit fl, input logic [LW-1:0] wa,
                            input logic [LW-1:0] fa, input logic [LB-1:0] line);
        acc_t a;
        logic [ADDR_W-1:0] ad;
        if (wb) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                ad = {wa, OFFSET_W'(i)};
                a.wr = 1'b1; a.addr = ad; a.data = line[i*N +: N];
                exp_acc.push_back(a);
                ref_mem[ad] = a.data;
            end
        end
        if (fl) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                ad = {fa, OFFSET_W'(i)};
                a.wr = 1'b0; a.addr = ad; a.data = '0;
                exp_acc.push_back(a);
                ref_fill[i*N +: N] = ref_mem[ad];
            end
        end
        exp_done.push_back(ref_fill);
    endtask

    // main_memory model: busy for mm_lat cycles per access, then waits for the
    // request to drop before it will start another access.
    always @(negedge clk) begin
        if (!reset) begin
            mm_phase = 0;
            mm_busy  = 1'b0;
        end else begin
            check("one_request", {bus.L2_read_request, bus.L2_write_request} == 2'b11, 1'b0);
            case (mm_phase)
                0: begin
                    if (bus.L2_read_request || bus.L2_write_request) begin
                        mm_wr   = bus.L2_write_request;
                        mm_addr = bus.L2_word_address;
                        mm_data = bus.L2_wdata;
                        if (exp_acc.size() == 0) begin
                            fail("unexpected_access");
                        end else begin
                            mm_e = exp_acc.pop_front();
                            check("acc_kind", mm_wr, mm_e.wr);
                            check("acc_addr", mm_addr, mm_e.addr);
                            if (mm_e.wr) check("acc_wdata", mm_data, mm_e.data);
                        end
                        mm_rdata = $urandom;
                        mm_busy  = 1'b1;
                        mm_left  = mm_lat;
                        mm_phase = 1;
                    end
                end
                1: begin
                    check("req_hold", bus.L2_read_request | bus.L2_write_request, 1'b1);
                    check("kind_stable", bus.L2_write_request, mm_wr);
                    check("addr_stable", bus.L2_word_address, mm_addr);
                    if (mm_wr) check("wdata_stable", bus.L2_wdata, mm_data);
                    mm_left--;
                    if (mm_left == 0) begin
                        mm_busy = 1'b0;
                        if (mm_wr) ram[mm_addr] = mm_data;
                        else mm_rdata = ram[mm_addr];
                        acc_done++;
                        mm_phase = 2;
                    end
                end
                default: begin
                    if (bus.L2_read_request || bus.L2_write_request) begin
                        check("addr_stable_end", bus.L2_word_address, mm_addr);
                        if (mm_wr) check("wdata_stable_end", bus.L2_wdata, mm_data);
                    end else begin
                        mm_rdata = $urandom;
                        mm_phase = 0;
                    end
                end
            endcase
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            check("done_pulse", prev_done, 1'b0);
            if (exp_done.size() == 0) begin
                fail("unexpected_done");
            end else begin
                ed = exp_done.pop_front();
                check("fill_line", bus.fill_line, ed);
            end
            done_cnt++;
        end
        prev_done = bus.done;
    end

    task automatic set_req(input bit wb, input bit fl, input logic [LW-1:0] wa,
                           input logic [LW-1:0] fa, input logic [LB-1:0] line);
        bus.req_wb         = wb;
        bus.req_fill       = fl;
        bus.wb_line_addr   = wa;
        bus.fill_line_addr = fa;
        bus.wb_line        = line;
    endtask

    task automatic do_op(input bit wb, input bit fl, input logic [LW-1:0] wa,
                         input logic [LW-1:0] fa, input logic [LB-1:0] line);
        int k;
        @(negedge clk);
        set_req(wb, fl, wa, fa, line);
        bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            fail("accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        model_op(wb, fl, wa, fa, line);
        @(posedge clk);
        #1;
        check("ready_fall", bus.req_ready, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((exp_done.size() != 0 || !bus.req_ready) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (exp_done.size() != 0 || !bus.req_ready) fail(nm);
        check("acc_left", LB'(exp_acc.size()), '0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ready"}, bus.req_ready, 1'b1);
        check({nm, "_done"},  bus.done, 1'b0);
        check({nm, "_rd"},    bus.L2_read_request, 1'b0);
        check({nm, "_wr"},    bus.L2_write_request, 1'b0);
        check({nm, "_addr"},  bus.L2_word_address, '0);
        check({nm, "_wdata"}, bus.L2_wdata, '0);
        check({nm, "_fill"},  bus.fill_line, '0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [LB-1:0] line;
        logic [LW-1:0] pool [4];
        logic [N-1:0]  wexp [4];
        logic [LW-1:0] wa, fa;
        int            base, d0, k;
        bit            wb, fl;

        for (int a = 0; a < 2**ADDR_W; a++) begin
            ram[a]     = init_word(a);
            ref_mem[a] = init_word(a);
        end
        for (int i = 0; i < 4; i++) begin
            ram[15'h2AF0 + i]     = 32'hA0 + 32'(i);
            ref_mem[15'h2AF0 + i] = 32'hA0 + 32'(i);
        end
        bus.req_valid = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, '0);

        // Reset asserted mid-clock: outputs settle without waiting for an edge.
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // Fill only.
        do_op(1'b0, 1'b1, '0, 13'h0ABC, '0);
        wait_idle("fill_only");
        check("fill_const", bus.fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Writeback only.
        d0 = done_cnt;
        do_op(1'b1, 1'b0, 13'h0001, '0, {32'h44, 32'h33, 32'h22, 32'h11});
        wait_idle("wb_only");
        wexp = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) check("wb_ram", ram[4 + i], wexp[i]);
        check("wb_done_cnt", LB'(done_cnt - d0), LB'(1));
        check("wb_keeps_fill", bus.fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Writeback then fill of the same line.
        line = {$urandom, $urandom, $urandom, $urandom};
        do_op(1'b1, 1'b1, 13'h1FFF, 13'h1FFF, line);
        wait_idle("wb_fill_same");
        check("same_line_fill", bus.fill_line, line);

        // Reset after fill word 1 completes.
        base = acc_done;
        d0   = done_cnt;
        do_op(1'b0, 1'b1, '0, 13'h0123, '0);
        k = 0;
        while (acc_done < base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (acc_done < base + 2) fail("mid_reset_wait");
        @(negedge clk);
        check("partial_fill", bus.fill_line[2*N-1:0], ref_fill[2*N-1:0]);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_acc.delete();
        exp_done.delete();
        ref_fill = '0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", LB'(done_cnt - d0), '0);
        #2 reset = 1'b1;
        do_op(1'b0, 1'b1, '0, 13'h0123, '0);
        wait_idle("after_reset_fill");

        // Zero-flag request: done right after acceptance, no memory traffic.
        base = acc_done;
        do_op(1'b0, 1'b0, 13'h0055, 13'h0066, '0);
        check("zero_done", bus.done, 1'b1);
        check("zero_no_rd", bus.L2_read_request, 1'b0);
        check("zero_no_wr", bus.L2_write_request, 1'b0);
        wait_idle("zero_flag");
        check("zero_no_access", LB'(acc_done - base), '0);

        // req_valid held through a busy operation with different request
        // contents; the second request is taken only once req_ready returns.
        d0 = done_cnt;
        @(negedge clk);
        set_req(1'b0, 1'b1, '0, 13'h0200, '0);
        bus.req_valid = 1'b1;
        if (!bus.req_ready) fail("hold_first_ready");
        model_op(1'b0, 1'b1, '0, 13'h0200, '0);
        @(negedge clk);
        line = {$urandom, $urandom, $urandom, $urandom};
        set_req(1'b1, 1'b1, 13'h0300, 13'h0300, line);
        k = 0;
        while (!bus.req_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) fail("hold_ready_return");
        check("hold_first_done", LB'(done_cnt - d0), LB'(1));
        model_op(1'b1, 1'b1, 13'h0300, 13'h0300, line);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_idle("hold_second");
        check("hold_second_fill", bus.fill_line, line);

        // Randomized operations over a small pool of lines to force overlap.
        for (int i = 0; i < 4; i++) pool[i] = LW'($urandom);
        for (int t = 0; t < 40; t++) begin
            mm_lat = $urandom_range(1, 3);
            wb = 1'($urandom);
            fl = 1'($urandom);
            wa = ($urandom_range(0, 4) == 0) ? LW'($urandom) : pool[$urandom_range(0, 3)];
            fa = ($urandom_range(0, 2) == 0) ? wa : pool[$urandom_range(0, 3)];
            line = {$urandom, $urandom, $urandom, $urandom};
            do_op(wb, fl, wa, fa, line);
            wait_idle("random_op");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("end_acc_empty", LB'(exp_acc.size()), '0);
        check("end_done_empty", LB'(exp_done.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
